// File: rtl/ysyx_25030085_mem_arbiter.sv
// ysyx_25030085_mem_arbiter: single-outstanding IFU/LSU arbiter for the memory port with timeout guard.
// Optional ARB_RR_EN: round-robin grant on contention instead of fixed LSU priority.
module ysyx_25030085_mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ifu_req_valid,
  output logic                ifu_req_ready,
  input  logic [ADDR_W-1:0]   ifu_addr,
  output logic                ifu_rsp_valid,
  output logic [DATA_W-1:0]   ifu_rsp_data,
  input  logic                lsu_req_valid,
  output logic                lsu_req_ready,
  input  logic [ADDR_W-1:0]   lsu_addr,
  input  logic                lsu_wen,
  input  logic [DATA_W-1:0]   lsu_wdata,
  input  logic [DATA_W/8-1:0] lsu_wmask,
  output logic                lsu_rsp_valid,
  output logic [DATA_W-1:0]   lsu_rsp_data,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic                mem_wen,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wmask,
  input  logic                mem_rsp_valid,
  input  logic [DATA_W-1:0]   mem_rsp_data,
  output logic                err_timeout
);
  localparam int MW = DATA_W / 8;
  localparam int CW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, SEND, WAIT} state_e;
  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              wen_q, wen_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [MW-1:0]     wmask_q, wmask_d;
  logic              owner_q, owner_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              err_q, err_d;
  logic              ifu_rv_q, ifu_rv_d, lsu_rv_q, lsu_rv_d;
  logic [DATA_W-1:0] ifu_rd_q, ifu_rd_d, lsu_rd_q, lsu_rd_d;
  logic              lsu_win, done;
  logic [DATA_W-1:0] rdata;
`ifdef ARB_RR_EN
  logic              last_q, last_d;
  // owner/last_grant encoding: 1 = LSU, 0 = IFU
  assign lsu_win = lsu_req_valid & (~ifu_req_valid | ~last_q);
`else
  assign lsu_win = lsu_req_valid;
`endif
  assign lsu_req_ready = (state_q == IDLE) & lsu_win;
  assign ifu_req_ready = (state_q == IDLE) & ifu_req_valid & ~lsu_win;
  assign mem_req_valid = (state_q == SEND);
  assign mem_addr      = addr_q;
  assign mem_wen       = wen_q;
  assign mem_wdata     = wdata_q;
  assign mem_wmask     = wmask_q;
  assign ifu_rsp_valid = ifu_rv_q;
  assign ifu_rsp_data  = ifu_rd_q;
  assign lsu_rsp_valid = lsu_rv_q;
  assign lsu_rsp_data  = lsu_rd_q;
  assign err_timeout   = err_q;
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wen_d   = wen_q;
    wdata_d = wdata_q;
    wmask_d = wmask_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    done    = 1'b0;
    rdata   = mem_rsp_data;
`ifdef ARB_RR_EN
    last_d  = last_q;
`endif
    if (state_q == IDLE) begin
      if (ifu_req_ready | lsu_req_ready) begin
        addr_d  = lsu_win ? lsu_addr : ifu_addr;
        wen_d   = lsu_win & lsu_wen;
        wdata_d = lsu_win ? lsu_wdata : '0;
        wmask_d = lsu_win ? lsu_wmask : '0;
        owner_d = lsu_win;
        cnt_d   = '0;
        state_d = SEND;
`ifdef ARB_RR_EN
        last_d  = lsu_win;
`endif
      end
    end else begin
      cnt_d = cnt_q + CW'(1);
      // a response in the final counted cycle still beats the timeout
      if (state_q == WAIT && mem_rsp_valid) begin
        done = 1'b1;
      end else if (cnt_q == CW'(TIMEOUT - 1)) begin
        done  = 1'b1;
        err_d = 1'b1;
        rdata = DATA_W'(32'hDEAD_BEEF);
      end else if (state_q == SEND && mem_req_ready) begin
        state_d = WAIT;
      end
      state_d = done ? IDLE : state_d;
    end
    ifu_rv_d = done & ~owner_q;
    lsu_rv_d = done & owner_q;
    ifu_rd_d = ifu_rv_d ? rdata : ifu_rd_q;
    lsu_rd_d = lsu_rv_d ? rdata : lsu_rd_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      wen_q    <= 1'b0;
      wdata_q  <= '0;
      wmask_q  <= '0;
      owner_q  <= 1'b0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
      ifu_rv_q <= 1'b0;
      lsu_rv_q <= 1'b0;
      ifu_rd_q <= '0;
      lsu_rd_q <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      wen_q    <= wen_d;
      wdata_q  <= wdata_d;
      wmask_q  <= wmask_d;
      owner_q  <= owner_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      ifu_rv_q <= ifu_rv_d;
      lsu_rv_q <= lsu_rv_d;
      ifu_rd_q <= ifu_rd_d;
      lsu_rd_q <= lsu_rd_d;
    end
  end
`ifdef ARB_RR_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) last_q <= 1'b0;
    else last_q <= last_d;
  end
`endif
endmodule

// File: tb/tb_ysyx_25030085_mem_arbiter.sv
// tb_ysyx_25030085_mem_arbiter: directed scenario bench for the memory arbiter (TIMEOUT overridden to 8).
module tb_ysyx_25030085_mem_arbiter;
  logic        clk = 1'b0, rst = 1'b1;
  logic        ifu_req_valid = 0, ifu_req_ready, ifu_rsp_valid;
  logic [31:0] ifu_addr = 0, ifu_rsp_data;
  logic        lsu_req_valid = 0, lsu_req_ready, lsu_wen = 0, lsu_rsp_valid;
  logic [31:0] lsu_addr = 0, lsu_wdata = 0, lsu_rsp_data;
  logic [3:0]  lsu_wmask = 0, mem_wmask;
  logic        mem_req_valid, mem_req_ready = 0, mem_wen, mem_rsp_valid = 0, err_timeout;
  logic [31:0] mem_addr, mem_wdata, mem_rsp_data = 0;
  int tests = 0, fails = 0;

  ysyx_25030085_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
    .ifu_rsp_valid(ifu_rsp_valid), .ifu_rsp_data(ifu_rsp_data),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
    .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
    .lsu_rsp_valid(lsu_rsp_valid), .lsu_rsp_data(lsu_rsp_data),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
    .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #1;
    tests++; if ({ifu_req_ready, lsu_req_ready, ifu_rsp_valid, lsu_rsp_valid, mem_req_valid, mem_wen, err_timeout} !== 7'b0) begin fails++; $display("FAIL reset_flags got %b exp 0", {ifu_req_ready, lsu_req_ready, ifu_rsp_valid, lsu_rsp_valid, mem_req_valid, mem_wen, err_timeout}); end
    tests++; if ({mem_addr, mem_wdata, mem_wmask, ifu_rsp_data, lsu_rsp_data} !== 132'b0) begin fails++; $display("FAIL reset_data got %h exp 0", {mem_addr, mem_wdata, mem_wmask, ifu_rsp_data, lsu_rsp_data}); end
    tick(); tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_ifu_read();
    ifu_req_valid = 1; ifu_addr = 32'h8000_0000;
    #1;
    tests++; if ({ifu_req_ready, lsu_req_ready} !== 2'b10) begin fails++; $display("FAIL t1_ready got %b exp 10", {ifu_req_ready, lsu_req_ready}); end
    tick();
    ifu_req_valid = 0; mem_req_ready = 1;
    tests++; if ({mem_req_valid, mem_wen, mem_wmask} !== 6'b100000) begin fails++; $display("FAIL t1_send got %b exp 100000", {mem_req_valid, mem_wen, mem_wmask}); end
    tests++; if (mem_addr !== 32'h8000_0000) begin fails++; $display("FAIL t1_addr got %h exp 80000000", mem_addr); end
    tick();
    mem_req_ready = 0; mem_rsp_valid = 1; mem_rsp_data = 32'h0010_0093;
    tests++; if (mem_req_valid !== 1'b0) begin fails++; $display("FAIL t1_wait_valid got %b exp 0", mem_req_valid); end
    tick();
    mem_rsp_valid = 0;
    tests++; if ({ifu_rsp_valid, lsu_rsp_valid} !== 2'b10) begin fails++; $display("FAIL t1_rsp_valid got %b exp 10", {ifu_rsp_valid, lsu_rsp_valid}); end
    tests++; if (ifu_rsp_data !== 32'h0010_0093) begin fails++; $display("FAIL t1_rsp_data got %h exp 00100093", ifu_rsp_data); end
    tick();
    tests++; if ({ifu_rsp_valid, lsu_rsp_valid} !== 2'b00) begin fails++; $display("FAIL t1_pulse_once got %b exp 00", {ifu_rsp_valid, lsu_rsp_valid}); end
    tests++; if (ifu_rsp_data !== 32'h0010_0093) begin fails++; $display("FAIL t1_data_hold got %h exp 00100093", ifu_rsp_data); end
  endtask

  task automatic test_arbitration();
    ifu_req_valid = 1; ifu_addr = 32'h8000_0004;
    lsu_req_valid = 1; lsu_addr = 32'h8000_0100; lsu_wen = 1; lsu_wdata = 32'h1234_5678; lsu_wmask = 4'hF;
    #1;
    tests++; if ({ifu_req_ready, lsu_req_ready} !== 2'b01) begin fails++; $display("FAIL t2_grant got %b exp 01", {ifu_req_ready, lsu_req_ready}); end
    tick();
    lsu_req_valid = 0; mem_req_ready = 1;
    tests++; if ({ifu_req_ready, lsu_req_ready, mem_req_valid, mem_wen} !== 4'b0011) begin fails++; $display("FAIL t2_send_flags got %b exp 0011", {ifu_req_ready, lsu_req_ready, mem_req_valid, mem_wen}); end
    tests++; if ({mem_addr, mem_wdata, mem_wmask} !== {32'h8000_0100, 32'h1234_5678, 4'hF}) begin fails++; $display("FAIL t2_fields got %h exp 80000100123456789f", {mem_addr, mem_wdata, mem_wmask}); end
    tick();
    mem_req_ready = 0; mem_rsp_valid = 1; mem_rsp_data = 32'hACCE_55ED;
    tick();
    mem_rsp_valid = 0; ifu_addr = 32'h8000_0008;
    tests++; if ({lsu_rsp_valid, ifu_rsp_valid, ifu_req_ready} !== 3'b101) begin fails++; $display("FAIL t2_ack_and_ifu_ready got %b exp 101", {lsu_rsp_valid, ifu_rsp_valid, ifu_req_ready}); end
    tests++; if (lsu_rsp_data !== 32'hACCE_55ED) begin fails++; $display("FAIL t2_ack_data got %h exp acce55ed", lsu_rsp_data); end
    tick();
    ifu_req_valid = 0; mem_req_ready = 1;
    tests++; if ({mem_addr, mem_wen, mem_wdata, mem_wmask} !== {32'h8000_0008, 1'b0, 32'h0, 4'h0}) begin fails++; $display("FAIL t2_ifu_fields got %h exp ifu read 80000008", {mem_addr, mem_wen, mem_wdata, mem_wmask}); end
    tick();
    mem_req_ready = 0; mem_rsp_valid = 1; mem_rsp_data = 32'h0000_0013;
    tick();
    mem_rsp_valid = 0;
    tests++; if ({ifu_rsp_valid, ifu_rsp_data} !== {1'b1, 32'h0000_0013}) begin fails++; $display("FAIL t2_ifu_rsp got %h exp 100000013", {ifu_rsp_valid, ifu_rsp_data}); end
    tick();
  endtask

  task automatic test_stall();
    ifu_req_valid = 1; ifu_addr = 32'h8000_0200;
    lsu_wen = 0;
    tick();
    lsu_req_valid = 1; lsu_addr = 32'h8000_0300;
    for (int i = 0; i < 5; i++) begin
      tests++; if ({mem_req_valid, mem_addr, ifu_req_ready, lsu_req_ready} !== {1'b1, 32'h8000_0200, 2'b00}) begin fails++; $display("FAIL t3_stall%0d got %h exp 1800002000", i, {mem_req_valid, mem_addr, ifu_req_ready, lsu_req_ready}); end
      tick();
    end
    ifu_req_valid = 0; lsu_req_valid = 0; mem_req_ready = 1;
    tick();
    mem_req_ready = 0; mem_rsp_valid = 1; mem_rsp_data = 32'h5555_AAAA;
    tick();
    mem_rsp_valid = 0;
    tests++; if ({ifu_rsp_valid, ifu_rsp_data, err_timeout} !== {1'b1, 32'h5555_AAAA, 1'b0}) begin fails++; $display("FAIL t3_rsp got %h exp 1 5555aaaa 0", {ifu_rsp_valid, ifu_rsp_data, err_timeout}); end
    tick();
  endtask

  task automatic test_timeout();
    lsu_req_valid = 1; lsu_addr = 32'h8000_0400; lsu_wen = 0;
    tick();
    lsu_req_valid = 0; mem_req_ready = 1;
    tick();
    mem_req_ready = 0;
    for (int i = 0; i < 6; i++) tick();
    tests++; if ({lsu_rsp_valid, err_timeout, mem_req_valid} !== 3'b000) begin fails++; $display("FAIL t4_before got %b exp 000", {lsu_rsp_valid, err_timeout, mem_req_valid}); end
    tick();
    tests++; if ({lsu_rsp_valid, ifu_rsp_valid, err_timeout, mem_req_valid} !== 4'b1010) begin fails++; $display("FAIL t4_abort got %b exp 1010", {lsu_rsp_valid, ifu_rsp_valid, err_timeout, mem_req_valid}); end
    tests++; if (lsu_rsp_data !== 32'hDEAD_BEEF) begin fails++; $display("FAIL t4_data got %h exp deadbeef", lsu_rsp_data); end
    ifu_req_valid = 1; ifu_addr = 32'h8000_0010;
    #1;
    tests++; if (ifu_req_ready !== 1'b1) begin fails++; $display("FAIL t4_idle got %b exp 1", ifu_req_ready); end
    tick();
    ifu_req_valid = 0; mem_req_ready = 1;
    tick();
    mem_req_ready = 0;
    for (int i = 0; i < 6; i++) tick();
    mem_rsp_valid = 1; mem_rsp_data = 32'h7777_0001;
    tick();
    mem_rsp_valid = 0;
    tests++; if ({ifu_rsp_valid, ifu_rsp_data, err_timeout} !== {1'b1, 32'h7777_0001, 1'b1}) begin fails++; $display("FAIL t4_coincide_sticky got %h exp 1 77770001 1", {ifu_rsp_valid, ifu_rsp_data, err_timeout}); end
    tick();
  endtask

  task automatic test_reset_in_wait();
    lsu_req_valid = 1; lsu_addr = 32'h8000_0500; lsu_wen = 1; lsu_wdata = 32'hCAFE_F00D; lsu_wmask = 4'h3;
    tick();
    lsu_req_valid = 0; mem_req_ready = 1;
    tick();
    mem_req_ready = 0;
    #2 rst = 1;
    #1;
    tests++; if ({mem_addr, mem_wdata, mem_wmask, mem_wen, mem_req_valid, err_timeout, lsu_rsp_data} !== 103'b0) begin fails++; $display("FAIL t5_async got %h exp 0", {mem_addr, mem_wdata, mem_wmask, mem_wen, mem_req_valid, err_timeout, lsu_rsp_data}); end
    tick();
    rst = 0; mem_rsp_valid = 1; mem_rsp_data = 32'h1111_2222;
    tick();
    mem_rsp_valid = 0;
    tests++; if ({lsu_rsp_valid, ifu_rsp_valid, lsu_rsp_data, mem_req_valid} !== 35'b0) begin fails++; $display("FAIL t5_ignored got %h exp 0", {lsu_rsp_valid, ifu_rsp_valid, lsu_rsp_data, mem_req_valid}); end
    tick();
  endtask

  task automatic test_back_to_back();
    ifu_req_valid = 1; ifu_addr = 32'h8000_0020;
    tick();
    mem_req_ready = 1;
    tick();
    mem_req_ready = 0; mem_rsp_valid = 1; mem_rsp_data = 32'h0000_0001;
    tick();
    mem_rsp_valid = 0; ifu_addr = 32'h8000_0024;
    tests++; if ({ifu_rsp_valid, ifu_req_ready} !== 2'b11) begin fails++; $display("FAIL t6_overlap got %b exp 11", {ifu_rsp_valid, ifu_req_ready}); end
    tick();
    ifu_req_valid = 0;
    tests++; if ({ifu_rsp_valid, mem_req_valid, mem_addr} !== {2'b01, 32'h8000_0024}) begin fails++; $display("FAIL t6_second got %h exp 0 1 80000024", {ifu_rsp_valid, mem_req_valid, mem_addr}); end
    mem_req_ready = 1;
    tick();
    mem_req_ready = 0; mem_rsp_valid = 1; mem_rsp_data = 32'h0000_0002;
    tick();
    mem_rsp_valid = 0;
    tests++; if ({ifu_rsp_valid, ifu_rsp_data} !== {1'b1, 32'h0000_0002}) begin fails++; $display("FAIL t6_second_rsp got %h exp 100000002", {ifu_rsp_valid, ifu_rsp_data}); end
    tick();
  endtask

  initial begin
    test_reset();
    test_ifu_read();
    test_arbitration();
    test_stall();
    test_timeout();
    test_reset_in_wait();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/ysyx_25030085_mem_arbiter.md
Name: ysyx_25030085_mem_arbiter

Overview:
Arbitrates the core's single memory port between the instruction fetch unit (IFU, read-only) and the load/store unit (LSU, read/write) of the ysyx_25030085 NPC. One outstanding transaction at a time. Each transaction follows a three-state sequence: request accept, memory request, response wait. A timeout counter guards against a memory that never responds.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width; wmask width is DATA_W/8
TIMEOUT, 255, maximum cycles spent in SEND plus WAIT before the transaction is aborted

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
ifu_req_valid  in  1  IFU read request
ifu_req_ready  out  1  IFU request accepted this cycle
ifu_addr  in  ADDR_W  IFU fetch address
ifu_rsp_valid  out  1  one-cycle IFU response pulse
ifu_rsp_data  out  DATA_W  fetched instruction
lsu_req_valid  in  1  LSU request
lsu_req_ready  out  1  LSU request accepted this cycle
lsu_addr  in  ADDR_W  LSU address
lsu_wen  in  1  1 = store, 0 = load
lsu_wdata  in  DATA_W  store data
lsu_wmask  in  DATA_W/8  byte write mask
lsu_rsp_valid  out  1  one-cycle LSU response pulse
lsu_rsp_data  out  DATA_W  load data (store: memory ack data, passed through)
mem_req_valid  out  1  request to memory
mem_req_ready  in  1  memory accepts request
mem_addr  out  ADDR_W  latched address
mem_wen  out  1  latched write enable (always 0 for IFU)
mem_wdata  out  DATA_W  latched write data (0 for IFU)
mem_wmask  out  DATA_W/8  latched mask (0 for IFU)
mem_rsp_valid  in  1  memory response / write ack
mem_rsp_data  in  DATA_W  memory read data
err_timeout  out  1  sticky timeout flag

Behaviour:
- Clock and reset: single clock clk; reset rst is asynchronous and active-high.
- Reset values: FSM=IDLE, all *_valid/ready=0, mem_* fields=0, rsp_data=0, err_timeout=0, counter=0, owner=IFU, last_grant=IFU.
- States:
  - IDLE: ready outputs are combinational. Exactly one ready is high, for the arbitration winner, and only if its valid is high.
  - Default arbitration: LSU wins when both are valid.
  - Handshake is valid&ready. On handshake: latch addr/wen/wdata/wmask (zeros for IFU), record owner, update last_grant, go to SEND.
  - SEND: mem_req_valid=1 with latched fields held stable. On mem_req_ready go to WAIT. Both req_ready outputs are 0.
  - WAIT: mem_req_valid=0. On mem_rsp_valid, register mem_rsp_data into the owner's rsp_data, pulse the owner's rsp_valid for exactly the next cycle, and go to IDLE.
- Latency: accept at T; mem_req_valid at T+1; with mem_req_ready at T+1 and mem_rsp_valid at T+2, rsp_valid is high at T+3.
- A new request may be accepted in the same cycle rsp_valid is high, since the FSM is already in IDLE.
- mem_rsp_valid in IDLE or SEND is ignored.
- rsp_data holds its last value when rsp_valid is 0.
- Timeout counter:
  - Cleared on entry to SEND; increments each cycle in SEND or WAIT.
  - When it reaches TIMEOUT without completion: set err_timeout (sticky until rst), pulse the owner's rsp_valid with data 32'hDEAD_BEEF, deassert mem_req_valid, go to IDLE.
  - If completion and timeout coincide, completion wins and err_timeout is not set.
- Requester valids dropping while not yet accepted is legal; the arbiter takes no action.
- Reset mid-transaction: immediate return to IDLE, no response pulse issued, the transaction is dropped.

Optional Feature:
ARB_RR_EN
- Defined: when both requesters are valid in IDLE, the grant goes to the requester not in last_grant (round-robin). A single valid requester always wins.
- Undefined: fixed priority, LSU over IFU; last_grant is unused.

Test Plan:
1. IFU only, ifu_addr=0x8000_0000, mem_req_ready=1 immediately, mem_rsp_data=0x0010_0093 one cycle later -> mem_wen=0, mem_wmask=0, ifu_rsp_valid pulses once with 0x0010_0093, lsu_rsp_valid stays 0.
2. Both valid in the same cycle, LSU store addr=0x8000_0100, wdata=0x1234_5678, wmask=4'hF -> lsu_req_ready=1, ifu_req_ready=0, mem fields match. After the ack, IFU is accepted next. With ARB_RR_EN and last_grant=LSU, IFU wins instead.
3. mem_req_ready held low for 5 cycles -> mem_req_valid and mem_addr stay stable for all 5 cycles, no ready to any requester, response follows normally.
4. Memory never responds, TIMEOUT=8 -> after 8 cycles in SEND/WAIT, err_timeout=1, owner rsp_data=0xDEAD_BEEF pulse, FSM back in IDLE, err_timeout stays 1 through subsequent transactions.
5. rst asserted in WAIT -> all outputs 0 asynchronously, no rsp_valid pulse, a later mem_rsp_valid is ignored.
6. Back-to-back IFU requests with ifu_req_valid held high -> second accept occurs in the cycle of the first ifu_rsp_valid.
